// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EX-stage forwarding, load-use and multi-cycle-unit interlocks, branch flush.
// Optional stall-cycle performance counter enabled by defining HZD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter int MD_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] ifid_rs1,
    input  logic [RA_W-1:0] ifid_rs2,
    input  logic            ifid_rs1_used,
    input  logic            ifid_rs2_used,
    input  logic            ifid_md,
    input  logic [RA_W-1:0] idex_rs1,
    input  logic [RA_W-1:0] idex_rs2,
    input  logic [RA_W-1:0] idex_rd,
    input  logic            idex_MemRead,
    input  logic            md_start,
    input  logic            exmem_RegWrite,
    input  logic            memwb_RegWrite,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            ex_br_taken,
    output logic [1:0]      forwardA,
    output logic [1:0]      forwardB,
    output logic            PCWrite,
    output logic            ifidWrite,
    output logic            idex_bubble,
    output logic            ifid_flush,
    output logic            md_busy,
    output logic            md_done,
    output logic [31:0]     perf_stall_cnt
);

    localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);

    logic [3:0]      md_cnt_q, md_cnt_d;
    logic [RA_W-1:0] pend_rd_q, pend_rd_d;
    logic            load_use, md_hazard, stall;

    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (exmem_RegWrite && exmem_rd != '0 && exmem_rd == idex_rs1)
            forwardA = 2'b10;
        else if (memwb_RegWrite && memwb_rd != '0 && memwb_rd == idex_rs1)
            forwardA = 2'b01;
        if (exmem_RegWrite && exmem_rd != '0 && exmem_rd == idex_rs2)
            forwardB = 2'b10;
        else if (memwb_RegWrite && memwb_rd != '0 && memwb_rd == idex_rs2)
            forwardB = 2'b01;
    end

    always_comb begin
        md_busy  = (md_cnt_q != 4'd0);
        md_done  = (md_cnt_q == 4'd1);
        load_use = idex_MemRead && idex_rd != '0 &&
                   ((ifid_rs1_used && idex_rd == ifid_rs1) ||
                    (ifid_rs2_used && idex_rd == ifid_rs2));
        // The pending result register only matters for data hazards; ifid_md is a structural conflict.
        md_hazard = md_busy &&
                    (ifid_md ||
                     (pend_rd_q != '0 &&
                      ((ifid_rs1_used && pend_rd_q == ifid_rs1) ||
                       (ifid_rs2_used && pend_rd_q == ifid_rs2))));
        stall = load_use || md_hazard;

        PCWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (ex_br_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (stall) begin
            PCWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // The MD op is older than any branch in EX, so branches never touch this state.
    always_comb begin
        md_cnt_d  = md_cnt_q;
        pend_rd_d = pend_rd_q;
        if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else if (md_start) begin
            md_cnt_d  = MD_LAT_C;
            pend_rd_d = idex_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q  <= 4'd0;
            pend_rd_q <= '0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            pend_rd_q <= pend_rd_d;
        end
    end

`ifdef HZD_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = PCWrite ? perf_cnt_q : perf_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_cnt_q <= 32'd0;
        else
            perf_cnt_q <= perf_cnt_d;
    end

    assign perf_stall_cnt = perf_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
